// File: rtl/cbfp_scaler.sv
// CBFP final normaliser: realigns each component to FINAL_REF and saturates to OUT_W.
// Latency 2 cycles, II=1. There is no backpressure: valid_out is valid_in delayed by two cycles.
module cbfp_scaler #(
   parameter int IN_W      = 16,
   parameter int OUT_W     = 13,
   parameter int SHIFT_W   = 5,
   parameter int REF_SUM   = 23,
   parameter int FINAL_REF = 9,
   parameter int LANES     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_in,
   input  logic signed [IN_W-1:0]    data_re_in   [0:LANES-1],
   input  logic signed [IN_W-1:0]    data_im_in   [0:LANES-1],
   input  logic        [SHIFT_W-1:0] index1_re_in [0:LANES-1],
   input  logic        [SHIFT_W-1:0] index1_im_in [0:LANES-1],
   input  logic        [SHIFT_W-1:0] index2_re_in [0:LANES-1],
   input  logic        [SHIFT_W-1:0] index2_im_in [0:LANES-1],
   output logic signed [OUT_W-1:0]   data_re_out  [0:LANES-1],
   output logic signed [OUT_W-1:0]   data_im_out  [0:LANES-1],
   output logic                      valid_out
);

   localparam int SUM_W   = SHIFT_W + 1;
   localparam int MAX_RSH = REF_SUM - 1 - FINAL_REF;
   localparam int MAX_SH  = (MAX_RSH > FINAL_REF) ? MAX_RSH : FINAL_REF;
   localparam int SH_W    = $clog2(MAX_SH + 1);
   localparam int WIDE_W  = IN_W + FINAL_REF;

   localparam logic [SUM_W-1:0]         REF_SUM_V   = SUM_W'(REF_SUM);
   localparam logic [SUM_W-1:0]         FINAL_REF_V = SUM_W'(FINAL_REF);
   localparam logic signed [WIDE_W-1:0] SAT_MAX     = WIDE_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [WIDE_W-1:0] SAT_MIN     = WIDE_W'(-(2 ** (OUT_W - 1)));

   // Per-component S1 state: the shift decision is resolved here so S2 is a pure shifter/clamp.
   typedef struct packed {
      logic                   zero;
      logic                   left;
      logic [SH_W-1:0]        sh;
      logic signed [IN_W-1:0] dat;
   } comp_t;

   function automatic comp_t decode(input logic signed [IN_W-1:0] dat,
                                    input logic [SHIFT_W-1:0]     i1,
                                    input logic [SHIFT_W-1:0]     i2);
      logic [SUM_W-1:0] sum;
      comp_t            c;
      sum    = {1'b0, i1} + {1'b0, i2};
      c.dat  = dat;
      c.zero = (sum >= REF_SUM_V);
      c.left = (sum <= FINAL_REF_V);
      if (c.zero)
         c.sh = '0;
      else if (c.left)
         c.sh = SH_W'(FINAL_REF_V - sum);
      else
         c.sh = SH_W'(sum - FINAL_REF_V);
      return c;
   endfunction

   function automatic logic signed [OUT_W-1:0] scale(input comp_t c);
      logic signed [WIDE_W-1:0] ext;
      logic signed [WIDE_W-1:0] res;
      ext = {{FINAL_REF{c.dat[IN_W-1]}}, c.dat};
      if (c.zero)
         res = '0;
      else if (c.left)
         res = ext <<< c.sh;
      else
         res = ext >>> c.sh;
      if (res > SAT_MAX)
         res = SAT_MAX;
      else if (res < SAT_MIN)
         res = SAT_MIN;
      return res[OUT_W-1:0];
   endfunction

   comp_t s1_re [0:LANES-1];
   comp_t s1_im [0:LANES-1];
   logic  s1_vld;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         valid_out <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            s1_re[i]       <= '0;
            s1_im[i]       <= '0;
            data_re_out[i] <= '0;
            data_im_out[i] <= '0;
         end
      end else begin
         s1_vld    <= valid_in;
         valid_out <= s1_vld;
         if (valid_in) begin
            for (int i = 0; i < LANES; i++) begin
               s1_re[i] <= decode(data_re_in[i], index1_re_in[i], index2_re_in[i]);
               s1_im[i] <= decode(data_im_in[i], index1_im_in[i], index2_im_in[i]);
            end
         end
         // Output registers hold across gaps so downstream sees the last beat until the next one.
         if (s1_vld) begin
            for (int i = 0; i < LANES; i++) begin
               data_re_out[i] <= scale(s1_re[i]);
               data_im_out[i] <= scale(s1_im[i]);
            end
         end
      end
   end

endmodule

// File: tb/tb_cbfp_scaler.sv
// Scoreboard bench for cbfp_scaler: directed corner beats, random stream, gaps and mid-stream reset.
module tb_cbfp_scaler;
   localparam int LANES = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              valid_in;
   logic signed [15:0] data_re_in   [0:LANES-1];
   logic signed [15:0] data_im_in   [0:LANES-1];
   logic        [4:0]  index1_re_in [0:LANES-1];
   logic        [4:0]  index1_im_in [0:LANES-1];
   logic        [4:0]  index2_re_in [0:LANES-1];
   logic        [4:0]  index2_im_in [0:LANES-1];
   logic signed [12:0] data_re_out  [0:LANES-1];
   logic signed [12:0] data_im_out  [0:LANES-1];
   logic              valid_out;

   cbfp_scaler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_in     (valid_in),
      .data_re_in   (data_re_in),
      .data_im_in   (data_im_in),
      .index1_re_in (index1_re_in),
      .index1_im_in (index1_im_in),
      .index2_re_in (index2_re_in),
      .index2_im_in (index2_im_in),
      .data_re_out  (data_re_out),
      .data_im_out  (data_im_out),
      .valid_out    (valid_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int re [LANES];
      int im [LANES];
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   rst_q = 1'b0;
   bit   mon_en = 1'b0;
   int   last_re [LANES];
   int   last_im [LANES];

   int st_re [LANES], st_im [LANES];
   int st_1r [LANES], st_1i [LANES], st_2r [LANES], st_2i [LANES];
   bit ov_en = 1'b0;
   int ov_re, ov_im;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model(input int v, input int i1, input int i2);
      int s, r;
      s = i1 + i2;
      if (s >= 23)
         r = 0;
      else if (s > 9)
         r = v >>> (s - 9);
      else
         r = v * (1 << (9 - s));
      if (r > 4095) r = 4095;
      if (r < -4096) r = -4096;
      return r;
   endfunction

   task automatic fill_rand(input int idx2_max);
      for (int i = 0; i < LANES; i++) begin
         st_re[i] = int'($urandom_range(0, 65535)) - 32768;
         st_im[i] = int'($urandom_range(0, 65535)) - 32768;
         st_1r[i] = int'($urandom_range(0, 31));
         st_1i[i] = int'($urandom_range(0, 31));
         st_2r[i] = int'($urandom_range(0, idx2_max));
         st_2i[i] = int'($urandom_range(0, idx2_max));
      end
   endtask

   // Lane 0 carries a hand-computed corner case; the other lanes stay random.
   task automatic lane0(input int re, input int i1r, input int i2r, input int xre,
                        input int im, input int i1i, input int i2i, input int xim);
      fill_rand(31);
      st_re[0] = re; st_1r[0] = i1r; st_2r[0] = i2r;
      st_im[0] = im; st_1i[0] = i1i; st_2i[0] = i2i;
      ov_en = 1'b1; ov_re = xre; ov_im = xim;
   endtask

   // Apply staged inputs now (just after an edge), then advance one cycle.
   task automatic beat(input bit vld);
      exp_t e;
      valid_in = vld;
      for (int i = 0; i < LANES; i++) begin
         data_re_in[i]   = 16'(st_re[i]);
         data_im_in[i]   = 16'(st_im[i]);
         index1_re_in[i] = 5'(st_1r[i]);
         index1_im_in[i] = 5'(st_1i[i]);
         index2_re_in[i] = 5'(st_2r[i]);
         index2_im_in[i] = 5'(st_2i[i]);
      end
      if (vld && rst_n) begin
         e.due = cyc + 2;
         for (int i = 0; i < LANES; i++) begin
            e.re[i] = model(st_re[i], st_1r[i], st_2r[i]);
            e.im[i] = model(st_im[i], st_1i[i], st_2i[i]);
         end
         if (ov_en) begin
            e.re[0] = ov_re;
            e.im[0] = ov_im;
         end
         sb.push_back(e);
      end
      ov_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      fill_rand(31);
      beat(1'b1);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst_q) begin
            chk("rst_valid_out", int'(valid_out), 0);
            for (int i = 0; i < LANES; i++) begin
               chk("rst_re", int'(data_re_out[i]), 0);
               chk("rst_im", int'(data_im_out[i]), 0);
               last_re[i] = 0;
               last_im[i] = 0;
            end
         end else if (valid_out) begin
            if (sb.size() == 0) begin
               chk("spurious_valid_out", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("latency_cycle", cyc, mon_e.due);
               for (int i = 0; i < LANES; i++) begin
                  chk($sformatf("re_lane%0d", i), int'(data_re_out[i]), mon_e.re[i]);
                  chk($sformatf("im_lane%0d", i), int'(data_im_out[i]), mon_e.im[i]);
                  last_re[i] = mon_e.re[i];
                  last_im[i] = mon_e.im[i];
               end
            end
         end else begin
            for (int i = 0; i < LANES; i++) begin
               chk("hold_re", int'(data_re_out[i]), last_re[i]);
               chk("hold_im", int'(data_im_out[i]), last_im[i]);
            end
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               chk("missing_valid_out", 0, 1);
               void'(sb.pop_front());
            end
         end
         if (!rst_n) sb.delete();
      end
   end

   initial begin
      int waited;
      rst_n    = 1'b0;
      valid_in = 1'b1;
      fill_rand(31);
      for (int i = 0; i < LANES; i++) begin
         last_re[i] = 0;
         last_im[i] = 0;
      end
      beat(1'b1);
      mon_en = 1'b1;
      beat(1'b1);
      rst_n = 1'b1;

      // Corner beats: left shift, saturation, pass-through, right shift, split sums, zero force.
      lane0(1,     0,  0,  512,   -4000,  0,  0, -4096); beat(1'b1);
      lane0(4000,  0,  0,  4095,  -100,   9,  0, -100);  beat(1'b1);
      lane0(-100,  12, 0,  -13,   100,    6,  6, 12);    beat(1'b1);
      lane0(800,   7,  5,  100,   -100,   4,  5, -100);  beat(1'b1);
      lane0(32767, 20, 3,  0,     -32768, 31, 31, 0);    beat(1'b1);
      lane0(-32768, 22, 0, -4,    32767,  10, 0, 4095);  beat(1'b1);
      lane0(-1,    23, 0,  0,     -1,     13, 9, -1);    beat(1'b1);

      // Continuous random stream with idx2 = 0.
      for (int b = 0; b < 32; b++) begin
         fill_rand(0);
         beat(1'b1);
      end

      // Gap pattern 1,0,1,1; invalid cycle carries junk that must be ignored.
      fill_rand(31); beat(1'b1);
      fill_rand(31); beat(1'b0);
      fill_rand(31); beat(1'b1);
      fill_rand(31); beat(1'b1);
      fill_rand(31); beat(1'b0);
      beat(1'b0);

      // Mid-stream reset: beats still in flight must never appear.
      for (int b = 0; b < 3; b++) begin
         fill_rand(31);
         beat(1'b1);
      end
      reset_pulse();
      for (int b = 0; b < 3; b++) begin
         fill_rand(31);
         beat(1'b1);
      end
      fill_rand(31);
      beat(1'b0);

      waited = 0;
      while (sb.size() != 0 && waited < 20) begin
         beat(1'b0);
         waited++;
      end
      chk("drain_pending", sb.size(), 0);
      repeat (4) beat(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
